// File: rtl/rni_txflit_arb.sv
// rtl/rni_txflit_arb.sv - RNI TX flit channel arbiter with L-credit tracking and deactivation drain
module rni_txflit_arb #(
    parameter int NUM_REQ    = 4,
    parameter int FLIT_WIDTH = 128,
    parameter int CRD_MAX    = 15,
    parameter int CRD_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [1:0]                    txlink_state,
    input  logic                          lcrd_return_en,
    input  logic                          TXLCRDV,
    output logic                          TXFLITPEND,
    output logic                          TXFLITV,
    output logic [FLIT_WIDTH-1:0]         TXFLIT,
    output logic                          txflit_avail,
    output logic [CRD_W-1:0]              crd_cnt,
    output logic                          crd_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] LINK_STOP  = 2'b00;
    localparam logic [1:0] LINK_RUN   = 2'b11;
    localparam logic [1:0] LINK_DEACT = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CRD_W-1:0]        crd_q, crd_d;
    logic                    err_q, err_d;
    logic                    flitv_q, flitv_d;
    logic [FLIT_WIDTH-1:0]   flit_q, flit_d;

    logic                    gnt_found;
    logic [PTR_W-1:0]        gnt_idx;
    logic [PTR_W-1:0]        cand;
    logic                    grant;
    logic                    ret_issue;
    logic                    crd_inc;
    logic                    crd_dec;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (txlink_state == LINK_RUN) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (txlink_state == LINK_DEACT)     state_d = S_DRAIN;
                else if (txlink_state == LINK_STOP) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (txlink_state == LINK_STOP)     state_d = S_IDLE;
                else if (txlink_state == LINK_RUN) state_d = S_ACTIVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign grant     = (state_q == S_ACTIVE) && pend_q && (crd_q != '0) && gnt_found;
    assign ret_issue = (state_q == S_DRAIN) && lcrd_return_en && (crd_q != '0) && pend_q;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        pend_d   = (state_d != S_IDLE);
        rr_ptr_d = rr_ptr_q;
        flitv_d  = grant || ret_issue;
        flit_d   = flit_q;
        if (grant) begin
            rr_ptr_d = PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
            flit_d   = req_flit[int'(gnt_idx)*FLIT_WIDTH +: FLIT_WIDTH];
        end else if (ret_issue) begin
            flit_d   = '0;
        end
    end

    // Credits are only meaningful while the link is up; leaving the link with any held is an error.
    always_comb begin
        crd_inc = TXLCRDV && (txlink_state != LINK_STOP);
        crd_dec = grant || ret_issue;
        crd_d   = crd_q;
        err_d   = err_q;
        if (TXLCRDV && (txlink_state == LINK_STOP)) err_d = 1'b1;
        if (crd_inc && !crd_dec) begin
            if (crd_q == CRD_W'(CRD_MAX)) err_d = 1'b1;
            else                          crd_d = crd_q + 1'b1;
        end else if (!crd_inc && crd_dec) begin
            crd_d = crd_q - 1'b1;
        end
        if (state_d == S_IDLE) begin
            if ((state_q != S_IDLE) && (crd_d != '0)) err_d = 1'b1;
            crd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pend_q   <= 1'b0;
            rr_ptr_q <= '0;
            crd_q    <= '0;
            err_q    <= 1'b0;
            flitv_q  <= 1'b0;
            flit_q   <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            rr_ptr_q <= rr_ptr_d;
            crd_q    <= crd_d;
            err_q    <= err_d;
            flitv_q  <= flitv_d;
            flit_q   <= flit_d;
        end
    end

    assign TXFLITPEND   = pend_q;
    assign TXFLITV      = flitv_q;
    assign TXFLIT       = flit_q;
    assign txflit_avail = |req_valid;
    assign crd_cnt      = crd_q;
    assign crd_err      = err_q;

endmodule

// File: tb/tb_rni_txflit_arb.sv
// tb/tb_rni_txflit_arb.sv - randomized self-checking bench for rni_txflit_arb
module tb_rni_txflit_arb;

    localparam int NUM_REQ    = 4;
    localparam int FLIT_WIDTH = 128;
    localparam int CRD_MAX    = 15;
    localparam int CRD_W      = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit;
    logic [NUM_REQ-1:0]            req_ready;
    logic [1:0]                    txlink_state;
    logic                          lcrd_return_en;
    logic                          TXLCRDV;
    logic                          TXFLITPEND;
    logic                          TXFLITV;
    logic [FLIT_WIDTH-1:0]         TXFLIT;
    logic                          txflit_avail;
    logic [CRD_W-1:0]              crd_cnt;
    logic                          crd_err;

    rni_txflit_arb #(
        .NUM_REQ(NUM_REQ), .FLIT_WIDTH(FLIT_WIDTH), .CRD_MAX(CRD_MAX), .CRD_W(CRD_W)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_flit(req_flit),
        .req_ready(req_ready), .txlink_state(txlink_state), .lcrd_return_en(lcrd_return_en),
        .TXLCRDV(TXLCRDV), .TXFLITPEND(TXFLITPEND), .TXFLITV(TXFLITV), .TXFLIT(TXFLIT),
        .txflit_avail(txflit_avail), .crd_cnt(crd_cnt), .crd_err(crd_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: link mode 0=down, 1=up, 2=draining
    int              m_mode, m_ptr, m_crd;
    bit              m_pend, m_err, m_v;
    logic [127:0]    m_flit;

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_crd = 0;
        m_pend = 0; m_err = 0; m_v = 0; m_flit = '0;
    endtask

    int link_order[4] = '{0, 2, 3, 1};

    initial begin
        int  cur_link_pos;
        int  len, crd_pct, val_pct, ret_pct;
        int  g, nmode, nc, ncrd, nptr;
        bit  g_ok, r_ok, nerr, nv;
        logic [127:0] nflit;
        logic [NUM_REQ-1:0] exp_ready;

        model_reset();
        rst = 1'b0; req_valid = '0; req_flit = '0; txlink_state = 2'b00;
        lcrd_return_en = 1'b0; TXLCRDV = 1'b0;
        @(posedge clk);
        cur_link_pos = 0;

        for (int p = 0; p < 160; p++) begin
            if ($urandom_range(0, 99) < 80) cur_link_pos = (cur_link_pos + 1) % 4;
            else                            cur_link_pos = $urandom_range(0, 3);
            len     = $urandom_range(2, 25);
            crd_pct = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(0, 80);
            val_pct = $urandom_range(10, 100);
            ret_pct = $urandom_range(30, 100);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                rst            = ($urandom_range(0, 299) != 0);
                txlink_state   = 2'(link_order[cur_link_pos]);
                TXLCRDV        = ($urandom_range(0, 99) < crd_pct);
                lcrd_return_en = ($urandom_range(0, 99) < ret_pct);
                for (int i = 0; i < NUM_REQ; i++)
                    req_valid[i] = ($urandom_range(0, 99) < val_pct);
                for (int i = 0; i < NUM_REQ * FLIT_WIDTH / 32; i++)
                    req_flit[i*32 +: 32] = $urandom;
                #1;

                // Arbitration per the model's rules
                g = -1;
                for (int d = 0; d < NUM_REQ; d++)
                    if (g < 0 && req_valid[(m_ptr + d) % NUM_REQ]) g = (m_ptr + d) % NUM_REQ;
                g_ok = (m_mode == 1) && m_pend && (m_crd > 0) && (g >= 0);
                r_ok = (m_mode == 2) && lcrd_return_en && (m_crd > 0) && m_pend;
                exp_ready = '0;
                if (g_ok) exp_ready[g] = 1'b1;

                check_val("req_ready",    128'(req_ready),    128'(exp_ready));
                check_val("txflit_avail", 128'(txflit_avail), 128'(req_valid != '0));
                check_val("TXFLITPEND",   128'(TXFLITPEND),   128'(m_pend));
                check_val("TXFLITV",      128'(TXFLITV),      128'(m_v));
                check_val("TXFLIT",       TXFLIT,             m_flit);
                check_val("crd_cnt",      128'(crd_cnt),      128'(m_crd));
                check_val("crd_err",      128'(crd_err),      128'(m_err));

                if (txlink_state == 2'b11)                        nmode = 1;
                else if (txlink_state == 2'b00)                   nmode = 0;
                else if (txlink_state == 2'b01 && m_mode == 1)    nmode = 2;
                else                                              nmode = m_mode;

                nerr = m_err;
                if (TXLCRDV && txlink_state == 2'b00) nerr = 1;
                nc = m_crd + ((TXLCRDV && txlink_state != 2'b00) ? 1 : 0) - ((g_ok || r_ok) ? 1 : 0);
                if (nc > CRD_MAX) begin nc = CRD_MAX; nerr = 1; end
                if (nmode == 0) begin
                    if (m_mode != 0 && nc != 0) nerr = 1;
                    nc = 0;
                end
                ncrd  = nc;
                nptr  = g_ok ? (g + 1) % NUM_REQ : m_ptr;
                nv    = g_ok || r_ok;
                nflit = g_ok ? req_flit[g*FLIT_WIDTH +: FLIT_WIDTH] : (r_ok ? 128'd0 : m_flit);

                @(posedge clk);
                if (!rst) begin
                    model_reset();
                end else begin
                    m_mode = nmode; m_pend = (nmode != 0); m_crd = ncrd; m_err = nerr;
                    m_ptr = nptr; m_v = nv; m_flit = nflit;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/rni_txflit_arb.md
# rni_txflit_arb

Shares the RNI TX flit channel among NUM_REQ internal requesters. Tracks TX L-credits granted by the link partner and gates issue on TX link state. During link deactivation it drains held credits as LCrdReturn flits. Sits between the RNI channel queues and the TX link pins, alongside the link-handshake block that supplies txlink_state and consumes txflit_avail.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- FLIT_WIDTH, 128, flit width in bits
- CRD_MAX, 15, maximum L-credits held
- CRD_W, 4, credit counter width; must satisfy 2^CRD_W > CRD_MAX

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the clk edge)
- req_valid  in  NUM_REQ  requester i has a flit
- req_flit  in  NUM_REQ*FLIT_WIDTH  flit i is at [i*FLIT_WIDTH +: FLIT_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; flit i is accepted when req_valid[i] & req_ready[i]
- txlink_state  in  2  {req,ack}: STOP=00, ACTIVATE=10, RUN=11, DEACTIVATE=01
- lcrd_return_en  in  1  credit return permitted
- TXLCRDV  in  1  one L-credit granted by the partner this cycle
- TXFLITPEND  out  1  flit-pending indication
- TXFLITV  out  1  flit valid
- TXFLIT  out  FLIT_WIDTH  flit data
- txflit_avail  out  1  = |req_valid (combinational); requests link activation
- crd_cnt  out  CRD_W  credits currently held
- crd_err  out  1  sticky protocol-error flag

## Operation
- FSM states IDLE, ACTIVE, DRAIN:
  - IDLE→ACTIVE when txlink_state==RUN.
  - ACTIVE→DRAIN when txlink_state==DEACTIVATE.
  - ACTIVE→IDLE when txlink_state==STOP.
  - DRAIN→IDLE when txlink_state==STOP.
  - DRAIN→ACTIVE when txlink_state==RUN.
  - Otherwise hold.
- TXFLITPEND is registered: next value = (next_state != IDLE).
- Grant condition, data flits: state==ACTIVE & TXFLITPEND & crd_cnt!=0 & |req_valid.
- Round-robin arbitration:
  - Grant the lowest index ≥ rr_ptr with req_valid set, wrapping modulo NUM_REQ.
  - On a grant, rr_ptr ← granted index + 1 (mod NUM_REQ).
  - With no grant, rr_ptr holds.
  - req_ready is combinational from the current req_valid and registered state.
- Return flits:
  - Issued in cycles where state==DRAIN & lcrd_return_en & crd_cnt!=0 & TXFLITPEND.
  - One per cycle, TXFLIT all zeros (LCrdReturn opcode 0).
  - req_ready stays 0 in DRAIN.
- Credit counter:
  - +1 on TXLCRDV.
  - −1 on each data grant or return-flit issue.
  - Increment and decrement in the same cycle leave crd_cnt unchanged.
  - Increment at CRD_MAX saturates and sets crd_err.
  - TXLCRDV while txlink_state==STOP is ignored (no count) and sets crd_err.
  - A decrement never occurs at 0, because the grant is gated.
- crd_err clears only on reset.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, crd_cnt 0, crd_err 0.
  - TXFLITPEND 0, TXFLITV 0, TXFLIT 0.
  - req_ready 0, because state is IDLE.
- Issue latency is 1 cycle. A flit accepted in cycle N drives TXFLITV=1 and TXFLIT in cycle N+1. With no issue, TXFLITV=0 and TXFLIT holds its last value.
- After the RUN transition:
  - State becomes ACTIVE one cycle after RUN is seen.
  - TXFLITPEND rises in the same cycle.
  - The first grant is possible in that cycle, so the first flit can appear 2 cycles after RUN.
- Maximum throughput is one flit per cycle while credits remain.
- crd_cnt reflects TXLCRDV at the next edge. A credit that arrives in cycle N is usable for a grant in cycle N+1.
- A grant in the last ACTIVE cycle is still issued (TXFLITV in DRAIN); this is legal on the link.
- Once state==IDLE, credits are dropped:
  - crd_cnt is forced to 0.
  - Entering IDLE with crd_cnt!=0 sets crd_err.
- Reset asserted mid-operation drops all credits, in-flight flits and rr_ptr, and returns all outputs to their reset values at the next edge.

## Test plan
- **Basic issue.** Reset, RUN, 3×TXLCRDV, req_valid=4'b0001 for 3 flits → TXFLITV on 3 consecutive cycles; crd_cnt goes 3→0; a 4th flit stalls with req_ready=0 until the next TXLCRDV.
- **Round-robin fairness.** RUN, 8 credits, req_valid=4'b1111 held → grant order 0,1,2,3,0,1,2,3; then req_valid=4'b1010 with rr_ptr=0 → grant order 1,3,1.
- **Simultaneous credit in/out.** crd_cnt=1, TXLCRDV coincident with a grant → crd_cnt stays 1; next-cycle grant allowed.
- **Deactivate drain.** crd_cnt=5, txlink_state RUN→DEACTIVATE, lcrd_return_en=1 → 5 all-zero TXFLITs on consecutive cycles, crd_cnt=0, no req_ready; STOP → IDLE, TXFLITPEND=0.
- **Errors.** 16×TXLCRDV with CRD_MAX=15 → crd_cnt=15, crd_err=1. TXLCRDV in STOP → crd_err=1, crd_cnt unchanged.
- **Reset mid-burst.** rst=0 for 1 cycle during a burst → next cycle TXFLITV=0, crd_cnt=0, state IDLE, rr_ptr=0, crd_err=0.
